// File: rtl/mem_read_sequencer_pkg.sv
// Shared constants and FSM encoding for the byte-wise 24-bit memory read sequencer.
package mem_read_sequencer_pkg;
   localparam int WORD_WIDTH     = 24;
   localparam int BYTE_WIDTH     = 8;
   localparam int BYTES_PER_WORD = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } mrs_state_e;
endpackage

// File: rtl/mem_read_sequencer_if.sv
// Control handshake, byte memory bus and data-register load path of the read sequencer.
interface mem_read_sequencer_if #(
   parameter int ADDR_WIDTH = 16
);
   import mem_read_sequencer_pkg::*;

   logic                  start;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd;
   logic [BYTE_WIDTH-1:0] mem_rdata;
   logic [WORD_WIDTH-1:0] data_out;
   logic                  load_en;

   modport master (
      input  start, addr, mem_rdata,
      output busy, done, mem_addr, mem_rd, data_out, load_en
   );

   modport slave (
      output start, addr, mem_rdata,
      input  busy, done, mem_addr, mem_rd, data_out, load_en
   );
endinterface

// File: rtl/mrs_byte_assembler.sv
// Shadow register collecting the three fetched bytes; lane order set by BIG_ENDIAN.
module mrs_byte_assembler
   import mem_read_sequencer_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  capture,
   input  logic [1:0]            idx,
   input  logic [BYTE_WIDTH-1:0] byte_in,
   output logic [WORD_WIDTH-1:0] word
);
   logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0] lanes_q;
   logic [1:0]                                lane;

   // Big-endian puts the byte at the base address in the top lane.
   assign lane = BIG_ENDIAN ? (2'(BYTES_PER_WORD - 1) - idx) : idx;

   always_ff @(posedge clk) begin
      if (reset)
         lanes_q <= '0;
      else if (capture)
         lanes_q[lane] <= byte_in;
   end

   assign word = lanes_q;
endmodule

// File: rtl/mem_read_sequencer.sv
// Fetches a 24-bit word as three byte reads and loads it into the data register.
// Optional MEM_READ_COUNT_EN adds a 16-bit completed-read counter port rd_count.
module mem_read_sequencer
   import mem_read_sequencer_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int RD_LATENCY = 1,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_read_sequencer_if.master bus
`ifdef MEM_READ_COUNT_EN
   ,
   output logic [15:0]          rd_count
`endif
);
   mrs_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [1:0]            idx_q;
   logic [2:0]            lat_q;
   logic [WORD_WIDTH-1:0] word_q;
   logic [WORD_WIDTH-1:0] shadow;
   logic                  capture;

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         IDLE: if (bus.start) state_d = REQ;
         REQ:  state_d = WAIT;
         WAIT: begin
            if (lat_q == 3'd1) begin
               capture = 1'b1;
               state_d = (idx_q == 2'(BYTES_PER_WORD - 1)) ? DONE : REQ;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // mem_addr is registered on entry to REQ so it holds its value between strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         base_q     <= '0;
         mem_addr_q <= '0;
         idx_q      <= '0;
         lat_q      <= '0;
         word_q     <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  base_q     <= bus.addr;
                  mem_addr_q <= bus.addr;
                  idx_q      <= '0;
               end
            end
            REQ: lat_q <= 3'(RD_LATENCY);
            WAIT: begin
               lat_q <= lat_q - 3'd1;
               if (capture && state_d == REQ) begin
                  idx_q      <= idx_q + 2'd1;
                  mem_addr_q <= base_q + ADDR_WIDTH'(idx_q + 2'd1);
               end
            end
            DONE:    word_q <= shadow;
            default: ;
         endcase
      end
   end

   mrs_byte_assembler #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_asm (
      .clk     (clk),
      .reset   (reset),
      .capture (capture),
      .idx     (idx_q),
      .byte_in (bus.mem_rdata),
      .word    (shadow)
   );

   // The last byte lands in the shadow on the edge entering DONE, so DONE shows it directly.
   assign bus.busy     = (state_q != IDLE);
   assign bus.mem_rd   = (state_q == REQ);
   assign bus.done     = (state_q == DONE);
   assign bus.load_en  = (state_q == DONE);
   assign bus.mem_addr = mem_addr_q;
   assign bus.data_out = (state_q == DONE) ? shadow : word_q;

`ifdef MEM_READ_COUNT_EN
   logic [15:0] rd_count_q;

   always_ff @(posedge clk) begin
      if (reset)
         rd_count_q <= '0;
      else if (state_q == DONE)
         rd_count_q <= rd_count_q + 16'd1;
   end

   assign rd_count = rd_count_q;
`endif
endmodule

// File: tb/tb_mem_read_sequencer.sv
// Directed bench: big-endian latency-1 instance and little-endian latency-3 instance.
module tb_mem_read_sequencer;
   import mem_read_sequencer_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1;
   int   n_tests = 0;
   int   n_fail  = 0;

   mem_read_sequencer_if #(.ADDR_WIDTH(16)) bus0 ();
   mem_read_sequencer_if #(.ADDR_WIDTH(16)) bus1 ();

`ifdef MEM_READ_COUNT_EN
   logic [15:0] cnt0, cnt1;
`endif

   mem_read_sequencer #(.ADDR_WIDTH(16), .RD_LATENCY(1), .BIG_ENDIAN(1'b1)) u0 (
      .clk   (clk),
      .reset (rst0),
      .bus   (bus0)
`ifdef MEM_READ_COUNT_EN
      ,
      .rd_count (cnt0)
`endif
   );

   mem_read_sequencer #(.ADDR_WIDTH(16), .RD_LATENCY(3), .BIG_ENDIAN(1'b0)) u1 (
      .clk   (clk),
      .reset (rst1),
      .bus   (bus1)
`ifdef MEM_READ_COUNT_EN
      ,
      .rd_count (cnt1)
`endif
   );

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      case (a)
         16'h0100: return 8'hAB;
         16'h0101: return 8'hCD;
         16'h0102: return 8'hEF;
         16'hFFFE: return 8'h11;
         16'hFFFF: return 8'h22;
         16'h0000: return 8'h33;
         default:  return a[7:0] ^ 8'h96;
      endcase
   endfunction

   // Memory models: data is valid only in the cycle exactly RD_LATENCY after mem_rd.
   logic [7:0]  p0_v = '0, p1_v = '0;
   logic [15:0] p0_a [8];
   logic [15:0] p1_a [8];
   always @(posedge clk) begin
      p0_v <= {p0_v[6:0], bus0.mem_rd};
      p1_v <= {p1_v[6:0], bus1.mem_rd};
      p0_a[0] <= bus0.mem_addr;
      p1_a[0] <= bus1.mem_addr;
      for (int i = 1; i < 8; i++) begin
         p0_a[i] <= p0_a[i-1];
         p1_a[i] <= p1_a[i-1];
      end
   end
   assign bus0.mem_rdata = p0_v[0] ? mem_byte(p0_a[0]) : 8'hEE;
   assign bus1.mem_rdata = p1_v[2] ? mem_byte(p1_a[2]) : 8'hEE;

   // Downstream data register fed by data_out/load_en.
   logic [23:0] dreg0 = '0;
   always @(posedge clk) if (bus0.load_en) dreg0 <= bus0.data_out;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full read on u0 starting in the current cycle (cycle 0); ends in cycle 9.
   task automatic read0(input logic [15:0] a, input logic [23:0] w, input string tag);
      logic [15:0] ea;
      bus0.addr  = a;
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
      bus0.addr  = 16'h5555;
      for (int c = 1; c <= 8; c++) begin
         check($sformatf("%s c%0d mem_rd", tag, c), bus0.mem_rd, (c == 1 || c == 3 || c == 5));
         if (c == 1 || c == 3 || c == 5) begin
            ea = a + 16'((c - 1) / 2);
            check($sformatf("%s c%0d mem_addr", tag, c), bus0.mem_addr, ea);
         end
         check($sformatf("%s c%0d done", tag, c), bus0.done, (c == 7));
         check($sformatf("%s c%0d load_en", tag, c), bus0.load_en, (c == 7));
         check($sformatf("%s c%0d busy", tag, c), bus0.busy, (c <= 7));
         if (c == 7) check($sformatf("%s data_out", tag), bus0.data_out, w);
         if (c == 8) begin
            check($sformatf("%s dreg", tag), dreg0, w);
            check($sformatf("%s data_out hold", tag), bus0.data_out, w);
         end
         tick();
      end
   endtask

   initial begin
      int nrd, nbl, ndone;
      rst0 = 1'b1; rst1 = 1'b1;
      bus0.start = 1'b0; bus0.addr = '0;
      bus1.start = 1'b0; bus1.addr = '0;
      tick();
      tick();
      check("rst busy", bus0.busy, 0);
      check("rst done", bus0.done, 0);
      check("rst mem_rd", bus0.mem_rd, 0);
      check("rst mem_addr", bus0.mem_addr, 0);
      check("rst data_out", bus0.data_out, 0);
      check("rst load_en", bus0.load_en, 0);
      check("rst u1 data_out", bus1.data_out, 0);
      rst0 = 1'b0; rst1 = 1'b0;
      tick();

      read0(16'h0100, 24'hABCDEF, "basic");
      read0(16'hFFFE, 24'h112233, "wrap");

      // start held high: reads every 8 cycles with one idle cycle between.
      bus0.addr  = 16'h0100;
      bus0.start = 1'b1;
      tick();
      nrd = 0; nbl = 0; ndone = 0;
      for (int c = 1; c <= 23; c++) begin
         if (bus0.mem_rd) begin
            nrd++;
            check($sformatf("held c%0d mem_rd slot", c), ((c % 8) == 1 || (c % 8) == 3 || (c % 8) == 5), 1);
         end
         if (!bus0.busy) nbl++;
         if (bus0.done) begin
            ndone++;
            check($sformatf("held c%0d done slot", c), c % 8, 7);
            check($sformatf("held c%0d data", c), bus0.data_out, 24'hABCDEF);
         end
         if (c == 23) bus0.start = 1'b0;
         tick();
      end
      check("held mem_rd count", nrd, 9);
      check("held idle cycles", nbl, 2);
      check("held done count", ndone, 3);

      // Reset in cycle 4 of a read.
      bus0.addr  = 16'h0100;
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
      tick();
      tick();
      tick();
      rst0 = 1'b1;
      tick();
      check("abort busy", bus0.busy, 0);
      check("abort mem_rd", bus0.mem_rd, 0);
      check("abort data_out", bus0.data_out, 0);
      check("abort done", bus0.done, 0);
      check("abort mem_addr", bus0.mem_addr, 0);
      rst0 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check($sformatf("abort idle%0d done", c), bus0.done, 0);
         tick();
      end
      read0(16'h0100, 24'hABCDEF, "post_abort");

`ifdef MEM_READ_COUNT_EN
      read0(16'h0200, {mem_byte(16'h0200), mem_byte(16'h0201), mem_byte(16'h0202)}, "cnt_a");
      read0(16'h0100, 24'hABCDEF, "cnt_b");
      check("rd_count after 3", cnt0, 16'd3);
      force u0.rd_count_q = 16'hFFFF;
      #1;
      release u0.rd_count_q;
      tick();
      check("rd_count preload", cnt0, 16'hFFFF);
      read0(16'h0100, 24'hABCDEF, "cnt_wrap");
      check("rd_count wrap", cnt0, 16'h0000);
`endif

      // Little-endian, latency 3.
      bus1.addr  = 16'h0100;
      bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         check($sformatf("le c%0d mem_rd", c), bus1.mem_rd, (c == 1 || c == 5 || c == 9));
         check($sformatf("le c%0d done", c), bus1.done, (c == 13));
         check($sformatf("le c%0d busy", c), bus1.busy, (c <= 13));
         if (c == 13) check("le data_out", bus1.data_out, 24'hEFCDAB);
         if (c == 14) check("le data_out hold", bus1.data_out, 24'hEFCDAB);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
